debug_reg_dump: RTL and testbench

Debug-side reader for the decode stage's register-file debug port. On a start pulse it freezes the pipeline through `stop_debug`/`debug_on` and walks the register file through the debug read address. It captures each 32-bit word and streams it as bytes over a valid/ready handshake to the UART transmitter. It sits between the debug UART and the instruction-decode stage, and is the consumer of `out_regDebug`.

---
 rtl/debug_reg_dump_pkg.sv | 24 ++
 rtl/debug_reg_dump_word_byte_serializer.sv | 48 ++++
 rtl/debug_reg_dump.sv | 135 +++++++++++++
 tb/tb_debug_reg_dump.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_reg_dump_pkg.sv
// Shared definitions for the register-file debug dump block.
package debug_reg_dump_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    HDR     = 3'd2,
    ADDR    = 3'd3,
    WAIT    = 3'd4,
    SEND    = 3'd5,
    RELEASE = 3'd6
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Words leave the serializer most-significant byte first.
  localparam bit MSB_FIRST = 1'b1;

  // Place a single byte where the serializer will emit it first.
  function automatic logic [31:0] first_byte_word(input logic [7:0] b, input bit msb_first);
    return msb_first ? {b, 24'h0} : {24'h0, b};
  endfunction

endpackage

// File: rtl/debug_reg_dump_word_byte_serializer.sv
// Loads a 32-bit word and hands it out one byte at a time over valid/ready.
// last_idx selects how many bytes go out (0 = one byte, 3 = full word).
module word_byte_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] word,
  input  logic [1:0]  last_idx,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last_accept
);

  logic [31:0] shreg;
  logic [1:0]  cnt;
  logic [1:0]  last;

  // The outgoing byte is a slice of the registered shift register.
  assign tx_data     = MSB_FIRST ? shreg[31:24] : shreg[7:0];
  assign last_accept = tx_valid & tx_ready & (cnt == last);

  // Shift register, byte count and valid flag; data only moves on acceptance.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg    <= '0;
      cnt      <= '0;
      last     <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= word;
      cnt      <= '0;
      last     <= last_idx;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (cnt == last) begin
        tx_valid <= 1'b0;
      end else begin
        shreg <= MSB_FIRST ? (shreg << 8) : (shreg >> 8);
        cnt   <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/debug_reg_dump.sv
// Freezes the pipeline, walks the register-file debug read port and streams
// a header byte followed by every register (MSB first) to the UART.
module debug_reg_dump
  import debug_reg_dump_pkg::*;
#(
  parameter int         NUM_REGS     = 32,
  parameter int         READ_LAT     = 1,
  parameter int         DRAIN_CYCLES = 2,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] reg_data,
  input  logic        tx_ready,
  output logic        debug_on,
  output logic        stop_debug,
  output logic [4:0]  debug_read_reg,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);
  localparam logic [3:0] DRAIN_LD  = 4'(DRAIN_CYCLES);
  localparam logic [2:0] WAIT_LD   = 3'(READ_LAT);

  state_t      state_q, state_d;
  logic [3:0]  drain_cnt;
  logic [2:0]  wait_cnt;
  logic [4:0]  index;

  logic        ser_load;
  logic        ser_clear;
  logic [31:0] ser_word;
  logic [1:0]  ser_last;
  logic        ser_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and serializer strobes. Counters leave their state on the
  // edge where they reach zero, so DRAIN lasts DRAIN_CYCLES cycles and WAIT
  // samples reg_data exactly READ_LAT edges after debug_read_reg was driven.
  always_comb begin
    state_d   = state_q;
    ser_load  = 1'b0;
    ser_clear = 1'b0;
    ser_word  = '0;
    ser_last  = 2'd0;
    if (state_q != IDLE && abort) begin
      state_d   = IDLE;
      ser_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE:    if (start && !abort) state_d = (DRAIN_CYCLES == 0) ? HDR : DRAIN;
        DRAIN:   if (drain_cnt <= 4'd1) state_d = HDR;
        HDR:     if (ser_done) state_d = ADDR;
        ADDR:    state_d = WAIT;
        WAIT: begin
          if (wait_cnt <= 3'd1) begin
            state_d  = SEND;
            ser_load = 1'b1;
            ser_word = reg_data;
            ser_last = 2'd3;
          end
        end
        SEND:    if (ser_done) state_d = (index == LAST_IDX) ? RELEASE : ADDR;
        RELEASE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
      // Header is a one-byte "word", loaded on whichever edge enters HDR.
      if (state_d == HDR && state_q != HDR) begin
        ser_load = 1'b1;
        ser_word = first_byte_word(HEADER, MSB_FIRST);
        ser_last = 2'd0;
      end
    end
  end

  // Registered status outputs follow the state being entered; counters and
  // the read index advance per the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      debug_on       <= 1'b0;
      stop_debug     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      debug_read_reg <= '0;
      drain_cnt      <= '0;
      wait_cnt       <= '0;
      index          <= '0;
    end else begin
      busy       <= (state_d != IDLE);
      done       <= (state_d == RELEASE);
      debug_on   <= (state_d != IDLE) && (state_d != RELEASE);
      stop_debug <= (state_d != IDLE) && (state_d != RELEASE);
      unique case (state_q)
        IDLE: begin
          drain_cnt <= DRAIN_LD;
          index     <= '0;
        end
        DRAIN: drain_cnt <= drain_cnt - 4'd1;
        ADDR: begin
          debug_read_reg <= index;
          wait_cnt       <= WAIT_LD;
        end
        WAIT: wait_cnt <= wait_cnt - 3'd1;
        SEND: if (ser_done && index != LAST_IDX) index <= index + 5'd1;
        default: ;
      endcase
    end
  end

  word_byte_serializer #(
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .clear       (ser_clear),
    .load        (ser_load),
    .word        (ser_word),
    .last_idx    (ser_last),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .last_accept (ser_done)
  );

endmodule

// File: tb/tb_debug_reg_dump.sv
// Directed bench: default-parameter dump (plain, back-pressure, extra start,
// abort, reset mid-dump) plus a small NUM_REGS=4 / READ_LAT=3 / DRAIN=0 build.
module tb_debug_reg_dump;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, tx_ready = 1'b0;
  logic [31:0] reg_data;
  logic        debug_on, stop_debug, tx_valid, busy, done;
  logic [4:0]  debug_read_reg;
  logic [7:0]  tx_data;

  logic        start_p = 1'b0, abort_p = 1'b0, tx_ready_p = 1'b1;
  logic [31:0] reg_data_p;
  logic        debug_on_p, stop_debug_p, tx_valid_p, busy_p, done_p;
  logic [4:0]  debug_read_reg_p, a_p1 = '0, a_p2 = '0;
  logic [7:0]  tx_data_p;

  int  n_chk = 0, n_fail = 0;
  int  rdy_mode = 0;
  bq_t q, qp;
  int  done_cnt = 0, done_cnt_p = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = '0;

  always #5 clk = ~clk;

  debug_reg_dump u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .reg_data(reg_data),
    .tx_ready(tx_ready), .debug_on(debug_on), .stop_debug(stop_debug),
    .debug_read_reg(debug_read_reg), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .done(done)
  );

  debug_reg_dump #(.NUM_REGS(4), .READ_LAT(3), .DRAIN_CYCLES(0)) u_dut_p (
    .clk(clk), .rst(rst), .start(start_p), .abort(abort_p), .reg_data(reg_data_p),
    .tx_ready(tx_ready_p), .debug_on(debug_on_p), .stop_debug(stop_debug_p),
    .debug_read_reg(debug_read_reg_p), .tx_data(tx_data_p), .tx_valid(tx_valid_p),
    .busy(busy_p), .done(done_p)
  );

  // Register-file models: r[i] = base + i. READ_LAT=1 is combinational,
  // READ_LAT=3 shows the addressed value only two edges after the change.
  assign reg_data = 32'h1000_0000 + {27'd0, debug_read_reg};
  always @(posedge clk) begin
    a_p1 <= debug_read_reg_p;
    a_p2 <= a_p1;
  end
  assign reg_data_p = 32'h2000_0000 + {27'd0, a_p2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] base, input int k);
    logic [31:0] w;
    if (k == 0) return 8'hA5;
    w = base + 32'((k - 1) / 4);
    return 8'(w >> (8 * (3 - ((k - 1) % 4))));
  endfunction

  task automatic check_stream(input string tag, input bq_t got, input logic [31:0] base, input int nexp);
    chk({tag, "_len"}, got.size(), nexp);
    for (int k = 0; k < got.size() && k < nexp; k++)
      chk($sformatf("%s[%0d]", tag, k), got[k], exp_byte(base, k));
  endtask

  // Ready source: tied high or ~30% random.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) tx_ready = 1'b1;
    else               tx_ready = ($urandom_range(99) < 30);
  end

  // Byte monitors and hold-while-stalled check, sampled mid-cycle.
  always @(negedge clk) begin
    if (stall_prev) begin
      chk("hold_valid", tx_valid, 1'b1);
      chk("hold_data", tx_data, data_prev);
    end
    stall_prev = tx_valid && !tx_ready && !rst && !abort;
    data_prev  = tx_data;
    if (tx_valid && tx_ready && !rst) q.push_back(tx_data);
    if (tx_valid_p && tx_ready_p && !rst) qp.push_back(tx_data_p);
    if (done) done_cnt++;
    if (done_p) done_cnt_p++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start, then watch cycle by cycle until done. Cycle 1 is the cycle
  // holding start; done_cyc is the cycle in which done is seen.
  task automatic run_dump(input int budget, input bit extra_start, output int done_cyc, output int on_low);
    int cyc;
    done_cyc = 0;
    on_low   = 0;
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    cyc = 1;
    chk("busy_before_edge", busy, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    while (done_cyc == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) chk("busy_rise", busy, 1'b1);
      if (done) done_cyc = cyc;
      else if (!(debug_on && stop_debug)) on_low++;
      @(posedge clk); #1;
      start = extra_start && busy && (debug_read_reg == 5'd3);
    end
    start = 1'b0;
    if (done_cyc == 0) chk("done_timeout", 32'(cyc), 32'(budget + 1));
  endtask

  initial begin
    int dcyc, low, n;

    // Reset state
    wait_cycles(3);
    @(negedge clk);
    chk("rst_debug_on", debug_on, 1'b0);
    chk("rst_stop_debug", stop_debug, 1'b0);
    chk("rst_read_reg", debug_read_reg, 5'd0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    wait_cycles(2);

    // Full dump, ready tied high
    q.delete(); done_cnt = 0;
    run_dump(400, 1'b0, dcyc, low);
    chk("full_done_cycle", 32'(dcyc), 32'd197);
    chk("full_freeze_held", 32'(low), 32'd0);
    wait_cycles(5);
    chk("full_done_once", 32'(done_cnt), 32'd1);
    chk("full_idle_stop", stop_debug, 1'b0);
    check_stream("full", q, 32'h1000_0000, 129);

    // Back-pressure at 30% with extra start pulses around r3
    q.delete(); done_cnt = 0; rdy_mode = 1;
    run_dump(3000, 1'b1, dcyc, low);
    chk("bp_done_seen", 32'(dcyc != 0), 32'd1);
    chk("bp_freeze_held", 32'(low), 32'd0);
    rdy_mode = 0;
    wait_cycles(5);
    chk("bp_done_once", 32'(done_cnt), 32'd1);
    check_stream("bp", q, 32'h1000_0000, 129);

    // Abort during r5 byte 2 (stream byte 23); that byte is still accepted
    q.delete(); done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (q.size() < 23 && n < 300) begin @(posedge clk); #1; n++; end
    chk("abort_reached", 32'(q.size()), 32'd23);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_stop_debug", stop_debug, 1'b0);
    chk("abort_debug_on", debug_on, 1'b0);
    chk("abort_tx_valid", tx_valid, 1'b0);
    wait_cycles(20);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    check_stream("abort", q, 32'h1000_0000, 24);

    // Restart after abort
    q.delete(); done_cnt = 0;
    run_dump(400, 1'b0, dcyc, low);
    chk("restart_done_cycle", 32'(dcyc), 32'd197);
    check_stream("restart", q, 32'h1000_0000, 129);
    wait_cycles(3);

    // Synchronous reset at r20
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (debug_read_reg != 5'd20 && n < 300) begin @(posedge clk); #1; n++; end
    chk("rst_mid_reached", debug_read_reg, 5'd20);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstm_debug_on", debug_on, 1'b0);
    chk("rstm_stop_debug", stop_debug, 1'b0);
    chk("rstm_read_reg", debug_read_reg, 5'd0);
    chk("rstm_tx_data", tx_data, 8'h00);
    chk("rstm_tx_valid", tx_valid, 1'b0);
    chk("rstm_busy", busy, 1'b0);
    wait_cycles(4);
    chk("rstm_stays_idle", busy, 1'b0);

    // Small build: 4 regs, READ_LAT 3, no drain -> 35 cycles, 17 bytes
    qp.delete(); done_cnt_p = 0;
    @(posedge clk); #1 start_p = 1'b1;
    @(posedge clk); #1 start_p = 1'b0;
    dcyc = 0; n = 1;
    while (dcyc == 0 && n < 200) begin
      @(negedge clk); n++;
      if (done_p) dcyc = n;
      @(posedge clk); #1;
    end
    chk("p_done_cycle", 32'(dcyc), 32'd35);
    wait_cycles(3);
    chk("p_done_once", 32'(done_cnt_p), 32'd1);
    check_stream("p", qp, 32'h2000_0000, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
